// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control FSM with memory wait-state handshake, optional bne/addi/j,
// sticky illegal-instruction trap and retired-instruction counter.
module mc_control_unit #(
  parameter bit          HAS_BNE  = 1'b1,
  parameter bit          HAS_ADDI = 1'b1,
  parameter bit          HAS_J    = 1'b1,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             memwrite,
  output logic             pcen,
  output logic             irwrite,
  output logic             regwrite,
  output logic             alusrca,
  output logic             iord,
  output logic             memtoreg,
  output logic             regdst,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       alucontrol,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StExec, StAluWb,
    StBeq, StBne, StAddiEx, StAddiWb, StJump, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic             trap_q;
  logic [CNT_W-1:0] instret_q;
  logic             retire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == StHalt) trap_q <= 1'b1;
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    memwrite   = 1'b0;
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b000;
    unique case (state_q)
      StFetch: begin
        mem_req    = 1'b1;
        alusrcb    = 2'b01;
        alucontrol = AluAdd;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        if (mem_ready) state_d = StDecode;
      end
      StDecode: begin
        alusrcb    = 2'b11;
        alucontrol = AluAdd;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExec;
          OpBeq:      state_d = StBeq;
          OpBne:      state_d = HAS_BNE  ? StBne    : StHalt;
          OpAddi:     state_d = HAS_ADDI ? StAddiEx : StHalt;
          OpJ:        state_d = HAS_J    ? StJump   : StHalt;
          default:    state_d = StHalt;
        endcase
      end
      StMemAdr: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
        if (op == OpLw)      state_d = StMemRd;
        else if (op == OpSw) state_d = StMemWr;
        else                 state_d = StHalt;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = StMemWb;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StMemWr: begin
        // Write strobe stays up through every wait cycle until memory accepts it.
        mem_req  = 1'b1;
        iord     = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = StFetch;
        end
      end
      StExec: begin
        alusrca = 1'b1;
        state_d = StAluWb;
        case (funct)
          6'b100000: alucontrol = AluAdd;
          6'b100010: alucontrol = AluSub;
          6'b100100: alucontrol = AluAnd;
          6'b100101: alucontrol = AluOr;
          6'b101010: alucontrol = AluSlt;
          default:   state_d    = StHalt;
        endcase
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StBeq, StBne: begin
        alusrca    = 1'b1;
        alucontrol = AluSub;
        pcsrc      = 2'b01;
        pcen       = (state_q == StBeq) ? zero : !zero;
        retire     = 1'b1;
        state_d    = StFetch;
      end
      StAddiEx: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        alucontrol = AluAdd;
        state_d    = StAddiWb;
      end
      StAddiWb: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StJump: begin
        pcsrc   = 2'b10;
        pcen    = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt: state_d = StHalt;
      default: state_d = StHalt;
    endcase
    // Strobes are masked combinationally so an in-flight access dies with the reset edge.
    if (!reset) begin
      mem_req    = 1'b0;
      memwrite   = 1'b0;
      pcen       = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      alusrca    = 1'b0;
      iord       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
    end
  end

  assign trap    = trap_q;
  assign instret = instret_q;

endmodule
